// File: rtl/serdes_ocm_pkg.sv
// rtl/serdes_ocm_pkg.sv - shared OCM geometry, table layout and streamer state/tag types
package serdes_ocm_pkg;

  localparam int OCM_DATA_W = 64;
  localparam int OCM_ADDR_W = 14;

  // Table layout shared with noise_128_wrapper and ISI_channel_ocm
  localparam int NOISE_BASE_DEF  = 0;
  localparam int NOISE_WORDS_DEF = 128;
  localparam int CHAN_BASE_DEF   = 128;
  localparam int CHAN_WORDS_DEF  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    N_RD   = 3'd1,
    N_WAIT = 3'd2,
    C_RD   = 3'd3,
    C_WAIT = 3'd4,
    FIN    = 3'd5
  } ocm_state_e;

  // sel: 0 = noise client, 1 = channel client
  typedef struct packed {
    logic       valid;
    logic [7:0] idx;
    logic       sel;
  } rd_tag_t;

endpackage

// File: rtl/ocm_rd_align.sv
// rtl/ocm_rd_align.sv - RD_LAT-deep tag pipe lining up issue strobes with OCM read data
module ocm_rd_align
  import serdes_ocm_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rstn,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t pipe [RD_LAT];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[RD_LAT-1];

endmodule

// File: rtl/ocm_table_streamer.sv
// rtl/ocm_table_streamer.sv - OCM table sequencer: noise table then channel table, with done_wait handshakes
// Optional per-client XOR checksums under OCM_TABLE_STREAMER_CHECKSUM_EN.
module ocm_table_streamer
  import serdes_ocm_pkg::*;
#(
  parameter int ADDR_W      = OCM_ADDR_W,
  parameter int DATA_W      = OCM_DATA_W,
  parameter int RD_LAT      = 1,
  parameter int NOISE_BASE  = NOISE_BASE_DEF,
  parameter int NOISE_WORDS = NOISE_WORDS_DEF,
  parameter int CHAN_BASE   = CHAN_BASE_DEF,
  parameter int CHAN_WORDS  = CHAN_WORDS_DEF,
  parameter int TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_data,
  output logic              load_mem_n,
  output logic [7:0]        location_n,
  input  logic              done_wait_n,
  output logic              load_mem_c,
  output logic [7:0]        location_c,
  input  logic              done_wait_c,
  output logic              busy,
  output logic              all_done,
  output logic              timeout_err
`ifdef OCM_TABLE_STREAMER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] csum_n,
  output logic [DATA_W-1:0] csum_c
`endif
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  ocm_state_e        state;
  logic [8:0]        rd_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [8:0]        cur_words;
  logic              in_rd;
  logic              issue;
  logic              rd_last;
  logic              wait_done;
  rd_tag_t           tag_in;
  rd_tag_t           tag_out;
  logic              strobe_n;
  logic              strobe_c;
  logic [DATA_W-1:0] mem_data_q;

  assign in_rd     = (state == N_RD) || (state == C_RD);
  assign cur_words = (state == C_RD) ? 9'(CHAN_WORDS) : 9'(NOISE_WORDS);
  assign issue     = in_rd && (rd_cnt < cur_words);
  // Stay in RD until the last issued word has come out of the align pipe
  assign rd_last   = in_rd && (rd_cnt == cur_words + 9'(RD_LAT - 1));
  assign wait_done = (state == N_WAIT) ? done_wait_n : done_wait_c;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      rd_cnt      <= '0;
      wait_cnt    <= '0;
      mem_addr    <= '0;
      busy        <= 1'b0;
      all_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= N_RD;
            busy        <= 1'b1;
            all_done    <= 1'b0;
            timeout_err <= 1'b0;
            rd_cnt      <= '0;
            mem_addr    <= ADDR_W'(NOISE_BASE);
          end
        end
        N_RD, C_RD: begin
          rd_cnt <= rd_cnt + 9'd1;
          if (issue && (rd_cnt != cur_words - 9'd1)) mem_addr <= mem_addr + 1'b1;
          if (rd_last) begin
            state    <= (state == N_RD) ? N_WAIT : C_WAIT;
            wait_cnt <= '0;
          end
        end
        N_WAIT, C_WAIT: begin
          if (wait_done) begin
            if (state == N_WAIT) begin
              state    <= C_RD;
              rd_cnt   <= '0;
              mem_addr <= ADDR_W'(CHAN_BASE);
            end else begin
              state <= FIN;
            end
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= FIN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        FIN: begin
          busy     <= 1'b0;
          all_done <= !timeout_err;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tag_in = '{valid: issue, idx: rd_cnt[7:0], sel: (state == C_RD)};

  ocm_rd_align #(.RD_LAT(RD_LAT)) u_rd_align (
    .clk     (clk),
    .rstn    (rstn),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign strobe_n   = tag_out.valid && !tag_out.sel;
  assign strobe_c   = tag_out.valid && tag_out.sel;
  assign load_mem_n = strobe_n;
  assign load_mem_c = strobe_c;
  assign location_n = strobe_n ? tag_out.idx : 8'd0;
  assign location_c = strobe_c ? tag_out.idx : 8'd0;
  assign mem_data   = tag_out.valid ? mem_rdata : mem_data_q;

  always_ff @(posedge clk) begin
    if (!rstn) mem_data_q <= '0;
    else       mem_data_q <= mem_data;
  end

`ifdef OCM_TABLE_STREAMER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      csum_n <= '0;
      csum_c <= '0;
    end else if ((state == IDLE) && start) begin
      csum_n <= '0;
      csum_c <= '0;
    end else begin
      if (strobe_n) csum_n <= csum_n ^ mem_rdata;
      if (strobe_c) csum_c <= csum_c ^ mem_rdata;
    end
  end
`endif

endmodule
